// File: rtl/gemm_pkg.sv
// Shared types for the tiled GeMM loop controller: FSM state and loop order.
package gemm_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } gemm_ctrl_state_t;

    typedef enum logic {
        OrderMNK = 1'b0,  // M outer, N middle, K inner
        OrderNMK = 1'b1   // N outer, M middle, K inner
    } gemm_order_e;

endpackage : gemm_pkg

// File: rtl/gemm_tile_counter.sv
// One loop dimension: counts 0, Step, 2*Step, ... and flags the final step
// for the given ceiling. The last test is one bit wider than the count so
// count + Step can never wrap past the ceiling.
module gemm_tile_counter #(
    parameter int AddrWidth = 16,
    parameter int Step      = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 tick_i,
    input  logic                 clear_i,
    input  logic [AddrWidth-1:0] ceil_i,
    output logic [AddrWidth-1:0] count_o,
    output logic                 last_o
);

    localparam logic [AddrWidth:0] StepExt = (AddrWidth + 1)'(Step);

    logic [AddrWidth-1:0] count_d, count_q;
    logic [AddrWidth:0]   next_w;

    assign next_w  = {1'b0, count_q} + StepExt;
    assign last_o  = (next_w >= {1'b0, ceil_i});
    assign count_o = count_q;

    // Next count: clear wins, otherwise step or wrap to zero on the last step.
    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (tick_i) begin
            count_d = last_o ? '0 : next_w[AddrWidth-1:0];
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : gemm_tile_counter

// File: rtl/gemm_tile_controller.sv
// Loop controller for the tiled GeMM accelerator. Walks a K-innermost loop
// nest over (M, K, N) with selectable outer order, applies backpressure on
// the operand stream and holds one finished tile until writeback takes it.
module gemm_tile_controller
    import gemm_pkg::*;
#(
    parameter int AddrWidth = 16,
    parameter int TileM     = 4,
    parameter int TileK     = 4,
    parameter int TileN     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 order_i,
    input  logic [AddrWidth-1:0] M_size_i,
    input  logic [AddrWidth-1:0] K_size_i,
    input  logic [AddrWidth-1:0] N_size_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic                 acc_first_o,
    output logic                 acc_last_o,
    output logic [AddrWidth-1:0] M_count_o,
    output logic [AddrWidth-1:0] K_count_o,
    output logic [AddrWidth-1:0] N_count_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [AddrWidth-1:0] out_m_o,
    output logic [AddrWidth-1:0] out_n_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    gemm_ctrl_state_t     state_d, state_q;
    gemm_order_e          order_d, order_q;
    logic [AddrWidth-1:0] m_size_d, m_size_q;
    logic [AddrWidth-1:0] k_size_d, k_size_q;
    logic [AddrWidth-1:0] n_size_d, n_size_q;
    logic                 err_d, err_q;
    logic                 out_valid_d, out_valid_q;
    logic [AddrWidth-1:0] out_m_d, out_m_q;
    logic [AddrWidth-1:0] out_n_d, out_n_q;

    logic cnt_clear;
    logic beat;
    logic k_last, m_last, n_last;
    logic k_tick, m_tick, n_tick;
    logic out_take;

    // A beat that completes a tile must not overwrite a tile writeback still holds.
    assign in_ready_o  = (state_q == StBusy) && !(out_valid_q && !out_ready_i && k_last);
    assign beat        = in_valid_i && in_ready_o;
    assign acc_first_o = beat && (K_count_o == '0);
    assign acc_last_o  = beat && k_last;
    assign out_take    = out_valid_q && out_ready_i;

    // Tick routing: K always innermost; the latched order picks middle vs outer.
    always_comb begin
        k_tick = beat;
        m_tick = 1'b0;
        n_tick = 1'b0;
        if (order_q == OrderMNK) begin
            n_tick = beat && k_last;
            m_tick = beat && k_last && n_last;
        end else begin
            m_tick = beat && k_last;
            n_tick = beat && k_last && m_last;
        end
    end

    gemm_tile_counter #(.AddrWidth(AddrWidth), .Step(TileM)) u_m_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .tick_i  (m_tick),
        .clear_i (cnt_clear),
        .ceil_i  (m_size_q),
        .count_o (M_count_o),
        .last_o  (m_last)
    );

    gemm_tile_counter #(.AddrWidth(AddrWidth), .Step(TileK)) u_k_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .tick_i  (k_tick),
        .clear_i (cnt_clear),
        .ceil_i  (k_size_q),
        .count_o (K_count_o),
        .last_o  (k_last)
    );

    gemm_tile_counter #(.AddrWidth(AddrWidth), .Step(TileN)) u_n_cnt (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .tick_i  (n_tick),
        .clear_i (cnt_clear),
        .ceil_i  (n_size_q),
        .count_o (N_count_o),
        .last_o  (n_last)
    );

    // FSM: start/size latch, end-of-nest detection, drain and completion.
    always_comb begin
        state_d   = state_q;
        order_d   = order_q;
        m_size_d  = m_size_q;
        k_size_d  = k_size_q;
        n_size_d  = n_size_q;
        err_d     = 1'b0;
        cnt_clear = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if ((M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0)) begin
                        err_d = 1'b1;
                    end else begin
                        m_size_d  = M_size_i;
                        k_size_d  = K_size_i;
                        n_size_d  = N_size_i;
                        order_d   = gemm_order_e'(order_i);
                        cnt_clear = 1'b1;
                        state_d   = StBusy;
                    end
                end
            end
            StBusy: begin
                if (beat && k_last && m_last && n_last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (out_take) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                cnt_clear = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // One-deep output buffer: a new tile load takes priority over the handshake clear.
    always_comb begin
        out_valid_d = out_valid_q;
        out_m_d     = out_m_q;
        out_n_d     = out_n_q;
        if (acc_last_o) begin
            out_valid_d = 1'b1;
            out_m_d     = M_count_o;
            out_n_d     = N_count_o;
        end else if (out_take) begin
            out_valid_d = 1'b0;
        end
    end

    // Control and buffer registers; reset discards any in-flight tile.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            order_q     <= OrderMNK;
            m_size_q    <= '0;
            k_size_q    <= '0;
            n_size_q    <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_m_q     <= '0;
            out_n_q     <= '0;
        end else begin
            state_q     <= state_d;
            order_q     <= order_d;
            m_size_q    <= m_size_d;
            k_size_q    <= k_size_d;
            n_size_q    <= n_size_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_m_q     <= out_m_d;
            out_n_q     <= out_n_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_m_o     = out_m_q;
    assign out_n_o     = out_n_q;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone) || err_q;
    assign err_o       = err_q;

endmodule : gemm_tile_controller

// File: tb/tb_gemm_tile_controller.sv
// Directed bench for gemm_tile_controller with hand-computed expectations.
module tb_gemm_tile_controller;

    localparam int AW = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic          order_i;
    logic [AW-1:0] M_size_i, K_size_i, N_size_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic          acc_first_o, acc_last_o;
    logic [AW-1:0] M_count_o, K_count_o, N_count_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [AW-1:0] out_m_o, out_n_o;
    logic          busy_o, done_o, err_o;

    int n_checks = 0;
    int n_fail   = 0;

    bit mon_en = 1'b0;
    int beat_k[$];
    int beat_f[$];
    int beat_l[$];
    int tile_m[$];
    int tile_n[$];

    always #5 clk_i = ~clk_i;

    gemm_tile_controller #(
        .AddrWidth (AW),
        .TileM     (4),
        .TileK     (4),
        .TileN     (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .order_i     (order_i),
        .M_size_i    (M_size_i),
        .K_size_i    (K_size_i),
        .N_size_i    (N_size_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .acc_first_o (acc_first_o),
        .acc_last_o  (acc_last_o),
        .M_count_o   (M_count_o),
        .K_count_o   (K_count_o),
        .N_count_o   (N_count_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_m_o     (out_m_o),
        .out_n_o     (out_n_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Record beats and output handshakes mid-cycle, away from the clock edge.
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (in_valid_i && in_ready_o) begin
                beat_k.push_back(int'(K_count_o));
                beat_f.push_back(int'(acc_first_o));
                beat_l.push_back(int'(acc_last_o));
            end
            if (out_valid_o && out_ready_i) begin
                tile_m.push_back(int'(out_m_o));
                tile_n.push_back(int'(out_n_o));
            end
        end
    end

    task automatic start_job(input int m, input int k, input int n, input int ord);
        beat_k.delete();
        beat_f.delete();
        beat_l.delete();
        tile_m.delete();
        tile_n.delete();
        M_size_i = AW'(m);
        K_size_i = AW'(k);
        N_size_i = AW'(n);
        order_i  = ord[0];
        start_i  = 1'b1;
        mon_en   = 1'b1;
        @(posedge clk_i);
        #1;
        start_i  = 1'b0;
    endtask

    // Cycle 1 is the first Busy cycle; returns the cycle in which done_o is seen.
    task automatic wait_done(input string tag, output int cyc);
        cyc = 1;
        while (!done_o && cyc < 300) begin
            @(posedge clk_i);
            #1;
            cyc++;
        end
        check({tag, "_done_seen"}, int'(done_o), 1);
        check({tag, "_busy_in_done"}, int'(busy_o), 1);
        @(posedge clk_i);
        #1;
        mon_en = 1'b0;
        check({tag, "_done_pulse_end"}, int'(done_o), 0);
        check({tag, "_busy_end"}, int'(busy_o), 0);
    endtask

    task automatic check_tiles(input string tag, input int cnt, input int em[4], input int en[4]);
        check({tag, "_tile_count"}, tile_m.size(), cnt);
        for (int i = 0; i < cnt; i++) begin
            if (i < tile_m.size()) begin
                check($sformatf("%s_tile%0d_m", tag, i), tile_m[i], em[i]);
                check($sformatf("%s_tile%0d_n", tag, i), tile_n[i], en[i]);
            end
        end
    endtask

    initial begin
        int cyc;
        int ok;

        rst_ni      = 1'b0;
        start_i     = 1'b0;
        order_i     = 1'b0;
        M_size_i    = '0;
        K_size_i    = '0;
        N_size_i    = '0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_err", int'(err_o), 0);
        check("rst_out_valid", int'(out_valid_o), 0);
        check("rst_in_ready", int'(in_ready_o), 0);
        check("rst_counts", int'(M_count_o | K_count_o | N_count_o), 0);
        check("rst_out_idx", int'(out_m_o | out_n_o), 0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // 8x8x8, order 0: 8 beats, N-middle tile order, done at cycle 10.
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        start_job(8, 8, 8, 0);
        check("o0_busy_after_start", int'(busy_o), 1);
        wait_done("o0", cyc);
        check("o0_done_cycle", cyc, 10);
        check("o0_beats", beat_k.size(), 8);
        check_tiles("o0", 4, '{0, 0, 4, 4}, '{0, 4, 0, 4});

        // 8x8x8, order 1: M-middle tile order.
        start_job(8, 8, 8, 1);
        wait_done("o1", cyc);
        check("o1_done_cycle", cyc, 10);
        check("o1_beats", beat_k.size(), 8);
        check_tiles("o1", 4, '{0, 4, 0, 4}, '{0, 0, 4, 4});

        // 5x6x3: ceilings 2*2*1 = 4 beats, K alternates 0/4.
        start_job(5, 6, 3, 0);
        wait_done("ceil", cyc);
        check("ceil_done_cycle", cyc, 6);
        check("ceil_beats", beat_k.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < beat_k.size()) begin
                check($sformatf("ceil_k%0d", i), beat_k[i], (i % 2) * 4);
                check($sformatf("ceil_first%0d", i), beat_f[i], (i % 2 == 0) ? 1 : 0);
                check($sformatf("ceil_last%0d", i), beat_l[i], (i % 2 == 1) ? 1 : 0);
            end
        end
        check_tiles("ceil", 2, '{0, 4, 0, 0}, '{0, 0, 0, 0});

        // Backpressure: 8x8x4 with writeback stalled after the first tile.
        out_ready_i = 1'b0;
        start_job(8, 8, 4, 0);
        cyc = 0;
        while (!out_valid_o && cyc < 20) begin
            @(posedge clk_i);
            #1;
            cyc++;
        end
        check("bp_first_tile_valid", int'(out_valid_o), 1);
        check("bp_nonlast_ready", int'(in_ready_o), 1);
        @(posedge clk_i);
        #1;
        ok = 1;
        for (int i = 0; i < 4; i++) begin
            if (in_ready_o !== 1'b0) ok = 0;
            @(posedge clk_i);
            #1;
        end
        check("bp_last_stalled", ok, 1);
        check("bp_beats_while_stalled", beat_k.size(), 3);
        check("bp_held_tile_m", int'(out_m_o), 0);
        out_ready_i = 1'b1;
        #1;
        check("bp_release_ready", int'(in_ready_o), 1);
        wait_done("bp", cyc);
        check("bp_beats", beat_k.size(), 4);
        check_tiles("bp", 2, '{0, 4, 0, 0}, '{0, 0, 0, 0});

        // Zero K size: err/done pulse once, never busy.
        M_size_i = AW'(8);
        K_size_i = '0;
        N_size_i = AW'(8);
        start_i  = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        check("zero_err", int'(err_o), 1);
        check("zero_done", int'(done_o), 1);
        check("zero_busy", int'(busy_o), 0);
        @(posedge clk_i);
        #1;
        check("zero_err_end", int'(err_o), 0);
        check("zero_done_end", int'(done_o), 0);
        check("zero_busy_end", int'(busy_o), 0);

        // Reset during Busy with a tile pending, then a clean full job.
        start_job(8, 8, 8, 0);
        repeat (3) @(posedge clk_i);
        #1;
        mon_en = 1'b0;
        check("mid_busy_before", int'(busy_o), 1);
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        check("mid_rst_busy", int'(busy_o), 0);
        check("mid_rst_out_valid", int'(out_valid_o), 0);
        check("mid_rst_in_ready", int'(in_ready_o), 0);
        check("mid_rst_counts", int'(M_count_o | K_count_o | N_count_o), 0);
        check("mid_rst_out_idx", int'(out_m_o | out_n_o), 0);
        check("mid_rst_done_err", int'(done_o | err_o), 0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        start_job(8, 8, 8, 0);
        wait_done("post", cyc);
        check("post_done_cycle", cyc, 10);
        check("post_beats", beat_k.size(), 8);
        check_tiles("post", 4, '{0, 0, 4, 4}, '{0, 4, 0, 4});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_gemm_tile_controller

// File: doc/gemm_tile_controller.md
# gemm_tile_controller

Loop controller for the tiled GeMM accelerator. It walks a K-innermost loop nest over (M, K, N) in tile steps of TileM/TileK/TileN, with a selectable outer-loop order. It applies valid/ready backpressure on the operand stream and holds one finished output tile in a one-deep buffer until the writeback side accepts it. It sits between the top-level configuration registers, the SRAM address generators and the PE array, and replaces the single-MAC controller.

## Interface
- AddrWidth, 16: width of sizes, counts and output indices.
- TileM, 4: M step per tile (PE array rows).
- TileK, 4: K step per operand beat.
- TileN, 4: N step per tile (PE array columns).

- clk_i  in  1  clock.
- rst_ni  in  1  synchronous, active-low reset, sampled on rising clk_i.
- start_i  in  1  start request; sampled only in Idle.
- order_i  in  1  loop order; 0 = M outer/N middle, 1 = N outer/M middle; latched on start.
- M_size_i, K_size_i, N_size_i  in  AddrWidth  problem sizes; latched on start.
- in_valid_i  in  1  operand beat available.
- in_ready_o  out  1  controller accepts the beat.
- acc_first_o  out  1  accepted beat is the first K step of a tile (PE clears accumulator).
- acc_last_o  out  1  accepted beat is the last K step of a tile.
- M_count_o, K_count_o, N_count_o  out  AddrWidth  current tile base offsets for address generation.
- out_valid_o  out  1  finished tile pending.
- out_ready_i  in  1  writeback accepts the tile.
- out_m_o, out_n_o  out  AddrWidth  base indices of the pending tile.
- busy_o  out  1  not Idle.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle pulse when start sees a zero size.

## Operation
- States: Idle, Busy, Drain, Done.
- Idle:
  - start_i=1 with all sizes non-zero: latch sizes and order, clear counters, go to Busy.
  - Any size zero: pulse err_o and done_o in the next cycle, stay in Idle.
- Counters: count = 0, S, 2S, … with last = (count + S >= size), computed at AddrWidth+1 bits so it cannot overflow. Step count per dimension = ceil(size/S).
- Beat = in_valid_i && in_ready_o. Each beat advances K.
  - K last wraps K to 0 and advances the middle counter.
  - Middle last wraps the middle counter and advances the outer counter.
  - Order 0: N middle, M outer. Order 1: M middle, N outer.
- acc_first_o = beat && K_count_o==0. acc_last_o = beat && K last.
- On an acc_last_o beat: out_valid_o is set the next cycle, and out_m_o/out_n_o are registered from the counts at that beat.
- out_valid_o clears on out_valid_o && out_ready_i, unless a new tile loads in the same cycle. If both happen in the same cycle, valid stays high and the indices update.
- in_ready_o = (state==Busy) && !(out_valid_o && !out_ready_i && next beat is acc_last). Non-last beats are never stalled by the output.
- The beat on which all three counters are last moves the state to Drain.
- Drain: wait until out_valid_o && out_ready_i, then go to Done.
- Done: done_o=1, counters cleared, go to Idle.
- start_i outside Idle is ignored. order_i and size changes after start are ignored.
- Reset mid-operation returns to Idle with everything cleared. An in-flight tile is discarded.

## Timing
- Reset values: every output is 0, state is Idle.
- Start accepted at cycle t puts the controller in Busy at t+1. The first beat is possible at t+1.
- out_valid_o rises 1 cycle after the acc_last beat.
- done_o rises 1 cycle after the final output handshake.
- Unstalled run: ceil(M/TileM)·ceil(N/TileN)·ceil(K/TileK) beats, plus 1 cycle to the final out_valid_o, plus 1 cycle to done_o when out_ready_i=1.
- busy_o is high in Busy, Drain and Done.

## Structure
- Package gemm_pkg holds:
  - the state enum gemm_ctrl_state_t;
  - the loop-order enum gemm_order_e (OrderMNK=0, OrderNMK=1).
- Sub-module gemm_tile_counter: holds a step parameter and has tick, clear, ceiling, count and last ports. It is instantiated three times, with tick routing muxed by the latched order.
- The one-deep output buffer stays inline.

## Test plan
- Sizes M=8, K=8, N=8, order 0, in_valid=1, out_ready=1:
  - 8 beats occur;
  - out tiles are (0,0), (0,4), (4,0), (4,4);
  - done_o pulses at start+10.
- Same sizes with order 1: out tiles are (0,0), (4,0), (0,4), (4,4).
- Sizes M=5, K=6, N=3:
  - ceiling behaviour gives 2·2·1 = 4 beats;
  - K_count_o sequence is 0, 4, 0, 4;
  - acc_first_o/acc_last_o alternate correctly.
- out_ready_i=0 for 5 cycles after the first tile:
  - the next non-last beat proceeds;
  - the last beat stalls (in_ready_o=0) until out_ready_i=1;
  - no tile is lost or duplicated.
- start with K_size=0: err_o and done_o pulse once, busy_o stays 0.
- rst_ni low for 1 cycle during Busy: all outputs return to 0, and a new start then runs a clean full job.
